pc_next_ctrl: RTL and testbench
===============================

Name: pc_next_ctrl

Overview:
- Drives the select side of the 4-way next-PC multiplexer in the jump-capable datapath.
- Holds the program counter register and computes the four candidate targets: sequential, branch, jump and jump-register.
- Generates the 2-bit select code and steps the PC through a valid/ready fetch handshake.
- Buffers a redirect that arrives while instruction memory is not ready, so no control transfer is lost.

Parameters:
- N, 32, PC and data width in bits.
- RESET_PC, 32'h0000_0000, PC value loaded on reset.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- fetch_ready  in  1  instruction memory accepts the current pc_out
- stall  in  1  pipeline hold; blocks PC update and redirect capture
- branch  in  1  decoded conditional-branch instruction
- zero  in  1  ALU zero flag (branch condition)
- jump  in  1  decoded J-type jump
- jr  in  1  decoded jump-register
- imm  in  N  sign-extended 16-bit immediate
- jaddr  in  26  J-type target field
- rs_data  in  N  register operand for jr
- pc_out  out  N  current PC, registered
- fetch_valid  out  1  pc_out is a valid fetch request
- pc_sel  out  2  next-PC select code to the mux
- pc_plus4  out  N  pc_out + 4, combinational
- redirect_pending  out  1  a buffered redirect is waiting
- misalign  out  1  one-cycle pulse when a jr target has bits [1:0] != 0
- fetch_count  out  32  count of accepted fetches

Behaviour:
- Reset (async, immediate): pc_out=RESET_PC, fetch_valid=0, pc_sel=00, redirect_pending=0, misalign=0, fetch_count=0, state=BOOT.
- Select encoding: 00 sequential (pc+4); 01 branch taken; 10 jump; 11 jr.
- Priority: jr > jump > (branch & zero) > sequential.
- pc_sel is registered: it reflects the decision taken at the last PC-update edge. It holds its value otherwise.
- Target arithmetic, all modulo 2^N, wraps silently:
  - branch target = pc_plus4 + (imm << 2)
  - jump target = {pc_plus4[31:28], jaddr, 2'b00}
  - jr target = {rs_data[N-1:2], 2'b00}; misalign pulses on the same edge if rs_data[1:0] != 0.
- State BOOT: fetch_valid=0 for exactly one cycle after reset deassertion, then go to RUN.
- State RUN: fetch_valid=1.
  - Accept = fetch_valid & fetch_ready & !stall.
  - On accept: pc_out <= selected target, pc_sel <= code, fetch_count++ (wraps at 2^32).
  - Redirect (jr|jump|branch&zero) with !stall & !fetch_ready: latch target and code into the buffer, redirect_pending=1, go to HOLD. pc_out is unchanged.
- State HOLD: fetch_valid=1, pc_out unchanged.
  - A newer non-stalled redirect overwrites the buffer (last wins).
  - On accept: pc_out <= buffered target if no new redirect is present, else the new target. pc_sel is updated to match, redirect_pending=0, fetch_count++, return to RUN.
- Stall dominates: no PC change, no buffer capture, no count change, regardless of fetch_ready.
- Reset mid-HOLD discards the buffered redirect.
- Latency: PC update is one clock after accept sampling. pc_plus4 tracks pc_out combinationally.

Test Plan:
- Reset with RESET_PC=32'h100, fetch_ready=1, no controls -> fetch_valid=0 on the first cycle. Then pc_out steps 100,104,108; pc_sel=00; fetch_count=3 after 3 accepts.
- pc_out=32'h200, branch=1, zero=1, imm=-2, ready -> pc_out=32'h1FC, pc_sel=01. Repeat with zero=0 -> 32'h204, pc_sel=00.
- pc_out=32'hF000_0010, jump=1, jaddr=26'h0000040 with branch=1, zero=1 also set -> pc_out=32'hF000_0100, pc_sel=10 (priority).
- jr=1, rs_data=32'h0000_3003 -> pc_out=32'h3000, pc_sel=11, misalign pulses for exactly one cycle.
- pc_out=32'h400, jump to 32'h800 while fetch_ready=0 -> redirect_pending=1, pc_out stays 32'h400. Raise fetch_ready -> pc_out=32'h800, pending clears. Assert rst while pending -> pc_out=RESET_PC and the buffer is lost.
- stall=1 with fetch_ready=1 and jump=1 for 3 cycles -> pc_out, fetch_count and pc_sel unchanged.
- pc_out=32'hFFFF_FFFC sequential -> wraps to 32'h0000_0000.

Source files
------------

// File: rtl/pc_next_ctrl.sv
// pc_next_ctrl: program counter and next-PC select for a jump-capable datapath.
//
// The module holds the PC and computes four candidate targets: sequential, branch,
// jump and jump-register. It walks the PC through a valid/ready fetch handshake.
// A redirect that arrives while instruction memory is not ready is buffered, so
// that no control transfer is lost.
//
// Ports:
//   clk, rst          rising-edge clock, asynchronous active-high reset
//   fetch_ready       instruction memory accepts pc_out this cycle
//   stall             pipeline hold; blocks PC update and redirect capture
//   branch, zero      conditional branch and its ALU condition
//   jump, jr          J-type jump, jump-register
//   imm               sign-extended immediate (word offset for branches)
//   jaddr             J-type target field
//   rs_data           register operand for jr
//   pc_out            registered current PC
//   fetch_valid       pc_out is a valid fetch request
//   pc_sel            select code of the last PC update (00 seq, 01 br, 10 j, 11 jr)
//   pc_plus4          pc_out + 4, combinational
//   redirect_pending  a buffered redirect is waiting for fetch_ready
//   misalign          one-cycle pulse when a taken jr target had bits [1:0] != 0
//   fetch_count       number of accepted fetches, wraps at 2^32
module pc_next_ctrl #(
  parameter int unsigned   N        = 32,
  parameter logic [N-1:0]  RESET_PC = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         fetch_ready,
  input  logic         stall,
  input  logic         branch,
  input  logic         zero,
  input  logic         jump,
  input  logic         jr,
  input  logic [N-1:0] imm,
  input  logic [25:0]  jaddr,
  input  logic [N-1:0] rs_data,
  output logic [N-1:0] pc_out,
  output logic         fetch_valid,
  output logic [1:0]   pc_sel,
  output logic [N-1:0] pc_plus4,
  output logic         redirect_pending,
  output logic         misalign,
  output logic [31:0]  fetch_count
);

  localparam logic [1:0] SelSeq    = 2'b00;
  localparam logic [1:0] SelBranch = 2'b01;
  localparam logic [1:0] SelJump   = 2'b10;
  localparam logic [1:0] SelJr     = 2'b11;

  localparam logic [N-1:0] PcStep = N'(4);

  typedef enum logic [1:0] {
    StBoot = 2'b00,
    StRun  = 2'b01,
    StHold = 2'b10
  } state_e;

  state_e       state_q, state_d;
  logic [N-1:0] pc_q, pc_d;
  logic [1:0]   sel_q, sel_d;
  logic [N-1:0] buf_tgt_q, buf_tgt_d;
  logic [1:0]   buf_sel_q, buf_sel_d;
  logic         pend_q, pend_d;
  logic         misalign_q, misalign_d;
  logic [31:0]  count_q, count_d;

  logic [N-1:0] br_tgt, jmp_tgt, jr_tgt;
  logic [N-1:0] new_tgt;
  logic [1:0]   new_sel;
  logic         redirect;

  // Candidate targets, all modulo 2^N.
  assign pc_plus4 = pc_q + PcStep;
  assign br_tgt   = pc_plus4 + (imm << 2);
  assign jmp_tgt  = {pc_plus4[N-1:28], jaddr, 2'b00};
  assign jr_tgt   = {rs_data[N-1:2], 2'b00};

  // Priority: jr > jump > taken branch > sequential.
  always_comb begin
    new_tgt  = pc_plus4;
    new_sel  = SelSeq;
    redirect = 1'b1;
    if (jr) begin
      new_tgt = jr_tgt;
      new_sel = SelJr;
    end else if (jump) begin
      new_tgt = jmp_tgt;
      new_sel = SelJump;
    end else if (branch && zero) begin
      new_tgt = br_tgt;
      new_sel = SelBranch;
    end else begin
      redirect = 1'b0;
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    sel_d      = sel_q;
    buf_tgt_d  = buf_tgt_q;
    buf_sel_d  = buf_sel_q;
    pend_d     = pend_q;
    count_d    = count_q;
    // In RUN/HOLD every non-stalled jr is consumed or buffered, so it pulses here.
    misalign_d = (state_q != StBoot) && !stall && jr && (rs_data[1:0] != 2'b00);

    unique case (state_q)
      StBoot: begin
        state_d = StRun;
      end
      StRun: begin
        if (!stall) begin
          if (fetch_ready) begin
            pc_d    = new_tgt;
            sel_d   = new_sel;
            count_d = count_q + 32'd1;
          end else if (redirect) begin
            buf_tgt_d = new_tgt;
            buf_sel_d = new_sel;
            pend_d    = 1'b1;
            state_d   = StHold;
          end
        end
      end
      StHold: begin
        if (!stall) begin
          if (fetch_ready) begin
            // A fresh redirect supersedes the buffered one.
            if (redirect) begin
              pc_d  = new_tgt;
              sel_d = new_sel;
            end else begin
              pc_d  = buf_tgt_q;
              sel_d = buf_sel_q;
            end
            pend_d  = 1'b0;
            count_d = count_q + 32'd1;
            state_d = StRun;
          end else if (redirect) begin
            buf_tgt_d = new_tgt;
            buf_sel_d = new_sel;
          end
        end
      end
      default: begin
        state_d = StBoot;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StBoot;
      pc_q       <= RESET_PC;
      sel_q      <= SelSeq;
      buf_tgt_q  <= '0;
      buf_sel_q  <= SelSeq;
      pend_q     <= 1'b0;
      misalign_q <= 1'b0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      sel_q      <= sel_d;
      buf_tgt_q  <= buf_tgt_d;
      buf_sel_q  <= buf_sel_d;
      pend_q     <= pend_d;
      misalign_q <= misalign_d;
      count_q    <= count_d;
    end
  end

  assign pc_out           = pc_q;
  assign fetch_valid      = (state_q != StBoot);
  assign pc_sel           = sel_q;
  assign redirect_pending = pend_q;
  assign misalign         = misalign_q;
  assign fetch_count      = count_q;

endmodule

// File: tb/tb_pc_next_ctrl.sv
// Testbench for pc_next_ctrl: directed scenarios followed by randomized traffic.
// All results are compared against a flag-based behavioural model of the fetch rules.
module tb_pc_next_ctrl;

  logic        clk;
  logic        rst;
  logic        fetch_ready;
  logic        stall;
  logic        branch;
  logic        zero;
  logic        jump;
  logic        jr;
  logic [31:0] imm;
  logic [25:0] jaddr;
  logic [31:0] rs_data;
  logic [31:0] pc_out;
  logic        fetch_valid;
  logic [1:0]  pc_sel;
  logic [31:0] pc_plus4;
  logic        redirect_pending;
  logic        misalign;
  logic [31:0] fetch_count;

  localparam logic [31:0] ResetPc = 32'h0000_0100;

  pc_next_ctrl #(
    .N       (32),
    .RESET_PC(ResetPc)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .fetch_ready     (fetch_ready),
    .stall           (stall),
    .branch          (branch),
    .zero            (zero),
    .jump            (jump),
    .jr              (jr),
    .imm             (imm),
    .jaddr           (jaddr),
    .rs_data         (rs_data),
    .pc_out          (pc_out),
    .fetch_valid     (fetch_valid),
    .pc_sel          (pc_sel),
    .pc_plus4        (pc_plus4),
    .redirect_pending(redirect_pending),
    .misalign        (misalign),
    .fetch_count     (fetch_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model state.
  logic [31:0] m_pc;
  logic [31:0] m_cnt;
  logic [31:0] m_buf_tgt;
  logic [1:0]  m_sel;
  logic [1:0]  m_buf_sel;
  bit          m_boot;
  bit          m_pend;
  bit          m_mis;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_all();
    check("pc_out", pc_out, m_pc);
    check("pc_plus4", pc_plus4, m_pc + 32'd4);
    check("fetch_valid", 32'(fetch_valid), 32'(!m_boot));
    check("pc_sel", 32'(pc_sel), 32'(m_sel));
    check("pending", 32'(redirect_pending), 32'(m_pend));
    check("misalign", 32'(misalign), 32'(m_mis));
    check("fetch_count", fetch_count, m_cnt);
  endtask

  task automatic model_reset();
    m_pc      = ResetPc;
    m_cnt     = 0;
    m_buf_tgt = 0;
    m_sel     = 0;
    m_buf_sel = 0;
    m_boot    = 1;
    m_pend    = 0;
    m_mis     = 0;
  endtask

  // Applies one clock edge worth of fetch rules to the model, using current inputs.
  task automatic model_edge();
    logic [31:0] p4;
    logic [31:0] tgt;
    logic [1:0]  code;
    bit          redir;
    m_mis = 0;
    if (m_boot) begin
      m_boot = 0;
      return;
    end
    if (stall) return;
    p4    = m_pc + 32'd4;
    redir = 1;
    if (jr) begin
      tgt   = rs_data & ~32'd3;
      code  = 2'd3;
      m_mis = (rs_data % 4) != 0;
    end else if (jump) begin
      tgt  = (p4 & 32'hF000_0000) + 32'(jaddr) * 32'd4;
      code = 2'd2;
    end else if (branch && zero) begin
      tgt  = p4 + imm * 32'd4;
      code = 2'd1;
    end else begin
      tgt   = p4;
      code  = 2'd0;
      redir = 0;
    end
    if (fetch_ready) begin
      if (m_pend && !redir) begin
        m_pc  = m_buf_tgt;
        m_sel = m_buf_sel;
      end else begin
        m_pc  = tgt;
        m_sel = code;
      end
      m_pend = 0;
      m_cnt  = m_cnt + 32'd1;
    end else if (redir) begin
      m_buf_tgt = tgt;
      m_buf_sel = code;
      m_pend    = 1;
    end
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic set_in(input bit rdy, input bit stl, input bit br, input bit z, input bit j,
                        input bit r, input logic [31:0] im, input logic [25:0] ja,
                        input logic [31:0] rs);
    fetch_ready = rdy;
    stall       = stl;
    branch      = br;
    zero        = z;
    jump        = j;
    jr          = r;
    imm         = im;
    jaddr       = ja;
    rs_data     = rs;
  endtask

  // Asynchronous reset pulse between clock edges.
  task automatic do_reset();
    rst = 1'b1;
    #2;
    model_reset();
    check_all();
    rst = 1'b0;
  endtask

  // Loads an arbitrary PC through an accepted jr.
  task automatic load_pc(input logic [31:0] v);
    set_in(1, 0, 0, 0, 0, 1, 0, 0, v);
    step();
  endtask

  initial begin
    set_in(1, 0, 0, 0, 0, 0, 0, 0, 0);
    rst = 1'b1;
    model_reset();
    #3;
    check_all();
    check("reset_fv", 32'(fetch_valid), 32'd0);
    rst = 1'b0;

    // Boot cycle, then three sequential accepts.
    step();
    check("boot_pc", pc_out, 32'h100);
    for (int i = 0; i < 3; i++) step();
    check("seq_pc", pc_out, 32'h10C);
    check("seq_cnt", fetch_count, 32'd3);

    // Taken and not-taken branch.
    load_pc(32'h200);
    set_in(1, 0, 1, 1, 0, 0, 32'hFFFF_FFFE, 0, 0);
    step();
    check("br_taken", pc_out, 32'h1FC);
    load_pc(32'h200);
    set_in(1, 0, 1, 0, 0, 0, 32'hFFFF_FFFE, 0, 0);
    step();
    check("br_not_taken", pc_out, 32'h204);

    // Jump beats a taken branch.
    load_pc(32'hF000_0010);
    set_in(1, 0, 1, 1, 1, 0, 32'hFFFF_FFFE, 26'h0000040, 0);
    step();
    check("jump_prio", pc_out, 32'hF000_0100);
    check("jump_sel", 32'(pc_sel), 32'd2);

    // Misaligned jr pulses once.
    load_pc(32'h0000_3003);
    check("jr_pc", pc_out, 32'h3000);
    check("jr_mis", 32'(misalign), 32'd1);
    set_in(1, 0, 0, 0, 0, 0, 0, 0, 0);
    step();
    check("jr_mis_clear", 32'(misalign), 32'd0);

    // Redirect held while memory not ready.
    load_pc(32'h400);
    set_in(0, 0, 0, 0, 1, 0, 0, 26'h0000200, 0);
    step();
    check("hold_pc", pc_out, 32'h400);
    check("hold_pend", 32'(redirect_pending), 32'd1);
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
    step();
    set_in(1, 0, 0, 0, 0, 0, 0, 0, 0);
    step();
    check("hold_release", pc_out, 32'h800);
    set_in(0, 0, 0, 0, 1, 0, 0, 26'h0000300, 0);
    step();
    set_in(1, 0, 0, 0, 0, 0, 0, 0, 0);
    do_reset();
    step();
    step();
    check("rst_drops_buf", pc_out, 32'h104);

    // Stall dominates.
    set_in(1, 1, 0, 0, 1, 0, 0, 26'h0000123, 0);
    for (int i = 0; i < 3; i++) step();
    check("stall_pc", pc_out, 32'h104);

    // Sequential wrap.
    load_pc(32'hFFFF_FFFC);
    set_in(1, 0, 0, 0, 0, 0, 0, 0, 0);
    step();
    check("wrap", pc_out, 32'h0);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      set_in(($urandom % 10) < 6, ($urandom % 10) < 2, ($urandom % 4) == 0, ($urandom % 2) == 0,
             ($urandom % 5) == 0, ($urandom % 6) == 0, $urandom, 26'($urandom), $urandom);
      if (($urandom % 60) == 0) do_reset();
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
